// File: rtl/ef_tmr32_fault_cond.sv
// Fault-pin conditioner for EF_TMR32: sync, polarity, glitch qualification, hold stretch, event count.
// Define EF_TMR32_FLT_LATCH_EN to make HOLD wait for an explicit flt_clr before releasing the fault.
module ef_tmr32_fault_cond #(
  parameter int FLT_CW  = 8,
  parameter int HOLD_CW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flt_in,
  input  logic               flt_pol,
  input  logic [FLT_CW-1:0]  flt_len,
  input  logic [HOLD_CW-1:0] hold_len,
  input  logic               sw_fault,
  input  logic               flt_clr,
  input  logic               cnt_clr,
  output logic               pwm_fault,
  output logic               flt_active,
  output logic               flt_event,
  output logic [7:0]         flt_cnt
);

  typedef enum logic [1:0] {IDLE, QUAL, FAULT, HOLD} state_t;

  state_t             state_q;
  logic               s1_q, s2_q;
  logic [FLT_CW-1:0]  qcnt_q;
  logic [HOLD_CW-1:0] hcnt_q;
  logic               evt_q;
  logic [7:0]         cnt_q;
  logic               active;
  logic               release_ok;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef EF_TMR32_FLT_LATCH_EN
  assign release_ok = flt_clr;
`else
  logic unused_flt_clr;
  assign unused_flt_clr = flt_clr;
  assign release_ok     = 1'b1;
`endif

  assign active     = flt_pol ? s2_q : ~s2_q;
  assign flt_active = active;
  assign pwm_fault  = (state_q == FAULT) || (state_q == HOLD);
  assign flt_event  = evt_q;
  assign flt_cnt    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      qcnt_q  <= '0;
      hcnt_q  <= '0;
      evt_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      s1_q  <= flt_in;
      s2_q  <= s1_q;
      evt_q <= 1'b0;

      // A clear that lands on the event cycle still counts that event.
      if (cnt_clr)
        cnt_q <= evt_q ? 8'd1 : 8'd0;
      else if (evt_q)
        cnt_q <= sat_inc8(cnt_q);

      if (!en) begin
        state_q <= IDLE;
        qcnt_q  <= '0;
        hcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sw_fault || (active && flt_len <= FLT_CW'(1))) begin
              state_q <= FAULT;
              evt_q   <= 1'b1;
            end else if (active) begin
              state_q <= QUAL;
              qcnt_q  <= flt_len - FLT_CW'(1);
            end
          end
          QUAL: begin
            if (sw_fault || (active && qcnt_q == FLT_CW'(1))) begin
              state_q <= FAULT;
              evt_q   <= 1'b1;
            end else if (!active) begin
              state_q <= IDLE;
            end else begin
              qcnt_q <= qcnt_q - FLT_CW'(1);
            end
          end
          FAULT: begin
            if (!(active || sw_fault)) begin
              state_q <= HOLD;
              hcnt_q  <= hold_len;
            end
          end
          HOLD: begin
            // Re-entry from HOLD is the same fault continuing, so no new event.
            if (active || sw_fault) begin
              state_q <= FAULT;
            end else if (hcnt_q == '0) begin
              if (release_ok) state_q <= IDLE;
            end else begin
              hcnt_q <= hcnt_q - HOLD_CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_tmr32_fault_cond.sv
// Bench for ef_tmr32_fault_cond: per-scenario vectors with a result scoreboard plus hand-built corner sequences.
module tb_ef_tmr32_fault_cond;
  logic        clk = 1'b0;
  logic        rst_n, en, flt_in, flt_pol, sw_fault, flt_clr, cnt_clr;
  logic [7:0]  flt_len;
  logic [15:0] hold_len;
  logic        pwm_fault, flt_active, flt_event;
  logic [7:0]  flt_cnt;

  always #5 clk = ~clk;

  ef_tmr32_fault_cond #(.FLT_CW(8), .HOLD_CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flt_in(flt_in), .flt_pol(flt_pol),
    .flt_len(flt_len), .hold_len(hold_len), .sw_fault(sw_fault), .flt_clr(flt_clr),
    .cnt_clr(cnt_clr), .pwm_fault(pwm_fault), .flt_active(flt_active),
    .flt_event(flt_event), .flt_cnt(flt_cnt)
  );

  // w: pin active for edges 1..w; also active for edges r0+1..r1; n: edges observed.
  typedef struct {
    bit pol; int len; int hold; int w; int r0; int r1; int n;
    int rise; int high; int drops; int evt;
  } vec_t;
  typedef struct { int rise; int high; int drops; int evt; } res_t;

  int   total = 0;
  int   bad   = 0;
  int   exp_cnt;
  int   lexp;
  res_t exp_q[$];
  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input bit pol, input int len, input int hold);
    en       = 1'b0;
    flt_pol  = pol;
    flt_len  = len[7:0];
    hold_len = hold[15:0];
    flt_in   = ~pol;
    sw_fault = 1'b0;
    repeat (4) tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    res_t e, m;
    bit   prev, act;
    e = '{v.rise, v.high, v.drops, v.evt};
    exp_q.push_back(e);
    settle(v.pol, v.len, v.hold);
    chk($sformatf("v%0d_active_idle", idx), flt_active, 0);
    en     = 1'b1;
    flt_in = v.pol;
    m      = '{0, 0, 0, 0};
    prev   = 1'b0;
    for (int k = 1; k <= v.n; k++) begin
      @(posedge clk);
      #1;
      if (pwm_fault && m.rise == 0) m.rise = k;
      if (pwm_fault) m.high++;
      if (prev && !pwm_fault) m.drops++;
      prev = pwm_fault;
      if (flt_event) m.evt++;
      if (k == 2) chk($sformatf("v%0d_active_sync", idx), flt_active, 1);
      act    = (k + 1 <= v.w) || (k + 1 > v.r0 && k + 1 <= v.r1);
      flt_in = act ? v.pol : ~v.pol;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d_rise_edge", idx), m.rise, e.rise);
    chk($sformatf("v%0d_high_cycles", idx), m.high, e.high);
    chk($sformatf("v%0d_drops", idx), m.drops, e.drops);
    chk($sformatf("v%0d_events", idx), m.evt, e.evt);
    chk($sformatf("v%0d_pwm_end", idx), pwm_fault, 0);
    exp_cnt += e.evt;
    chk($sformatf("v%0d_cnt", idx), flt_cnt, exp_cnt);
  endtask

  initial begin
    //        pol len hold  w  r0  r1   n  rise high drops evt
    vt[0] = '{1'b1,  4, 10,  3,  0,  0, 25,   0,   0,  0, 0};
    vt[1] = '{1'b1,  4, 10, 20,  0,  0, 40,   6,  28,  1, 1};
    vt[2] = '{1'b0,  0,  5,  1,  0,  0, 15,   3,   7,  1, 1};
    vt[3] = '{1'b1,  1,  0,  2,  0,  0, 10,   3,   3,  1, 1};
    vt[4] = '{1'b1,  2,  3,  1,  0,  0, 10,   0,   0,  0, 0};
    vt[5] = '{1'b1,  2,  3,  2,  0,  0, 15,   4,   5,  1, 1};
    vt[6] = '{1'b0,  7,  1,  6,  0,  0, 15,   0,   0,  0, 0};
    vt[7] = '{1'b1, 10,  2, 10,  0,  0, 20,  12,   4,  1, 1};
    vt[8] = '{1'b1,  1, 10,  5, 11, 15, 35,   3,  26,  1, 1};
    vt[9] = '{1'b0,  1,  0,  1,  0,  0, 10,   3,   2,  1, 1};

    rst_n = 1'b0; en = 1'b0; flt_in = 1'b0; flt_pol = 1'b1; sw_fault = 1'b0;
    flt_clr = 1'b1; cnt_clr = 1'b0; flt_len = 8'd0; hold_len = 16'd0;
    exp_cnt = 0;
    #12;
    chk("rst_pwm", pwm_fault, 0);
    chk("rst_event", flt_event, 0);
    chk("rst_cnt", flt_cnt, 0);
    chk("rst_active_pol1", flt_active, 0);
    flt_pol = 1'b0;
    #1;
    chk("rst_active_pol0", flt_active, 1);
    flt_pol = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vt[i]) run_vec(i, vt[i]);

    // en dropped mid-QUAL: qualification must restart from scratch
    settle(1'b1, 8, 4);
    en = 1'b1; flt_in = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    tick();
    chk("enq_pwm_low", pwm_fault, 0);
    en = 1'b1;
    repeat (7) tick();
    chk("enq_not_yet", pwm_fault, 0);
    tick();
    chk("enq_restart_pwm", pwm_fault, 1);
    chk("enq_restart_evt", flt_event, 1);
    exp_cnt++;

    // en dropped mid-HOLD
    settle(1'b1, 1, 10);
    en = 1'b1; flt_in = 1'b1;
    repeat (3) tick();
    flt_in = 1'b0;
    repeat (5) tick();
    chk("enh_in_hold", pwm_fault, 1);
    en = 1'b0;
    tick();
    chk("enh_pwm_low", pwm_fault, 0);
    exp_cnt++;
    chk("enh_cnt_kept", flt_cnt, exp_cnt);
    en = 1'b1;
    tick();
    chk("enh_stays_idle", pwm_fault, 0);

    // counter saturation and clear priority, driven by software faults
    settle(1'b1, 1, 0);
    en = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clear", flt_cnt, 0);
    for (int i = 0; i < 255; i++) begin
      sw_fault = 1'b1;
      tick();
      if (i == 0) chk("sw_evt_high", flt_event, 1);
      sw_fault = 1'b0;
      tick();
      if (i == 0) chk("sw_evt_one_cycle", flt_event, 0);
      tick();
    end
    chk("cnt_reach_ff", flt_cnt, 255);
    sw_fault = 1'b1;
    tick();
    sw_fault = 1'b0;
    tick();
    tick();
    chk("cnt_saturate", flt_cnt, 255);
    sw_fault = 1'b1;
    tick();
    sw_fault = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_with_evt", flt_cnt, 1);
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_alone", flt_cnt, 0);
    exp_cnt = 0;

    // release behaviour without flt_clr
`ifdef EF_TMR32_FLT_LATCH_EN
    lexp = 1;
`else
    lexp = 0;
`endif
    settle(1'b1, 1, 2);
    flt_clr = 1'b0;
    en = 1'b1; flt_in = 1'b1;
    repeat (2) tick();
    flt_in = 1'b0;
    repeat (5) tick();
    chk("latch_in_hold", pwm_fault, 1);
    repeat (13) tick();
    chk("latch_no_clr", pwm_fault, lexp);
    flt_clr = 1'b1;
    tick();
    flt_clr = 1'b0;
    chk("latch_clr_release", pwm_fault, 0);
    exp_cnt++;
    chk("latch_cnt", flt_cnt, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
